// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle between the operand serializer (master) and the adder (slave).
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             i_start;
    logic             i_valid;
    logic             i_bit1;
    logic             i_bit2;
    logic             busy;
    logic             sum;
    logic             sum_valid;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             done;

    modport master (
        output i_start, i_valid, i_bit1, i_bit2,
        input  busy, sum, sum_valid, result, carry, done
    );

    modport slave (
        input  i_start, i_valid, i_bit1, i_bit2,
        output busy, sum, sum_valid, result, carry, done
    );
endinterface

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder built from two half adders; the serial slice of the adder.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0, c0, c1;

    half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

    assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder: one bit pair per accepted cycle, carry kept in a single flop,
// serial sum out plus the assembled parallel result and final carry.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
)(
    input  logic          i_clk,
    input  logic          i_rst,
    serial_adder_if.slave bus
);
    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cin_q, cin_d;
    logic             sum_q, sum_d;
    logic             sum_valid_q, sum_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             busy_o, done_o;
    logic             fa_s, fa_cout;
    logic             accept;
    logic             last_bit;

    assign accept   = (state_q == ST_ADD) && bus.i_valid;
    assign last_bit = (cnt_q == CNT_LAST);

    full_adder_cell u_fa (
        .a    (bus.i_bit1),
        .b    (bus.i_bit2),
        .cin  (cin_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.i_start) state_d = ST_ADD;
            ST_ADD:  if (accept && last_bit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == ST_ADD) || (state_q == ST_DONE);
        done_o = (state_q == ST_DONE);
    end

    // A stall leaves carry, counter and result untouched; sum keeps its last bit.
    always_comb begin
        cnt_d       = cnt_q;
        cin_d       = cin_q;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
        result_d    = result_q;
        carry_d     = carry_q;
        if ((state_q == ST_IDLE) && bus.i_start) begin
            cnt_d    = '0;
            cin_d    = 1'b0;
            result_d = '0;
            carry_d  = 1'b0;
        end else if (accept) begin
            sum_d       = fa_s;
            sum_valid_d = 1'b1;
            result_d    = {fa_s, result_q[WIDTH-1:1]};
            cin_d       = fa_cout;
            if (last_bit) carry_d = fa_cout;
            else          cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q       <= '0;
            cin_q       <= 1'b0;
            sum_q       <= 1'b0;
            sum_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            cin_q       <= cin_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
        end
    end

    assign bus.busy      = busy_o;
    assign bus.done      = done_o;
    assign bus.sum       = sum_q;
    assign bus.sum_valid = sum_valid_q;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder against an arithmetic (A+B) reference.
module tb_serial_adder;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    logic exp_sum;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic noise_bit(input int noise);
        if (noise == 1) return 1'b1;
        if (noise == 2) return 1'($urandom);
        return 1'b0;
    endfunction

    // noise: 0 = quiet, 1 = start held high while busy, 2 = random start/valid junk while busy
    task automatic add_word(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [31:0] stall_mask, input int noise,
                            output int ncyc, output logic [W-1:0] stream,
                            output logic [W-1:0] res, output logic cy);
        logic [W:0] total;
        int k, cyc;
        logic acc;
        total  = {1'b0, a} + {1'b0, b};
        stream = '0;
        bus.i_start = 1'b1;
        bus.i_valid = noise_bit(noise);
        bus.i_bit1  = 1'($urandom);
        bus.i_bit2  = 1'($urandom);
        step();
        chk("start_busy", 32'(bus.busy), 1);
        chk("start_result_clr", 32'(bus.result), 0);
        chk("start_carry_clr", 32'(bus.carry), 0);
        chk("start_sum_valid", 32'(bus.sum_valid), 0);
        chk("start_sum_hold", 32'(bus.sum), 32'(exp_sum));
        k = 0;
        cyc = 0;
        while (k < W && cyc < 8 * W) begin
            bus.i_start = noise_bit(noise);
            acc = !stall_mask[cyc % 32];
            bus.i_valid = acc;
            bus.i_bit1  = acc ? a[k] : 1'($urandom);
            bus.i_bit2  = acc ? b[k] : 1'($urandom);
            step();
            if (acc) begin
                exp_sum   = total[k];
                stream[k] = bus.sum;
                k++;
            end
            chk("sum_valid", 32'(bus.sum_valid), 32'(acc));
            chk("sum_bit", 32'(bus.sum), 32'(exp_sum));
            chk("done_timing", 32'(bus.done), 32'(k == W));
            chk("busy_add", 32'(bus.busy), 1);
            cyc++;
        end
        if (k < W) chk("word_timeout", 32'(k), W);
        ncyc = cyc;
        res  = bus.result;
        cy   = bus.carry;
        chk("result", 32'(bus.result), 32'(total[W-1:0]));
        chk("carry", 32'(bus.carry), 32'(total[W]));
        chk("stream", 32'(stream), 32'(total[W-1:0]));
        // DONE cycle: start/valid here must be ignored and the FSM must fall back to IDLE.
        bus.i_start = noise_bit(noise);
        bus.i_valid = noise_bit(noise);
        step();
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_done", 32'(bus.done), 0);
        chk("idle_sum_valid", 32'(bus.sum_valid), 0);
        chk("result_held", 32'(bus.result), 32'(total[W-1:0]));
        chk("carry_held", 32'(bus.carry), 32'(total[W]));
        bus.i_start = 1'b0;
        bus.i_valid = 1'b0;
    endtask

    initial begin
        int ncyc;
        logic [W-1:0] stream, res;
        logic cy;
        n_checks = 0;
        n_err    = 0;
        exp_sum  = 1'b0;
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_bit1  = 1'b0;
        bus.i_bit2  = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_sum", 32'(bus.sum), 0);
        chk("rst_sum_valid", 32'(bus.sum_valid), 0);
        chk("rst_result", 32'(bus.result), 0);
        chk("rst_carry", 32'(bus.carry), 0);
        chk("rst_done", 32'(bus.done), 0);
        rst = 1'b0;

        // valid without start in IDLE does nothing
        bus.i_valid = 1'b1;
        bus.i_bit1  = 1'b1;
        bus.i_bit2  = 1'b1;
        step();
        step();
        chk("idle_valid_busy", 32'(bus.busy), 0);
        chk("idle_valid_sv", 32'(bus.sum_valid), 0);
        chk("idle_valid_res", 32'(bus.result), 0);
        bus.i_valid = 1'b0;

        // basic add
        add_word(8'h5A, 8'h33, 32'h0, 0, ncyc, stream, res, cy);
        chk("basic_stream", 32'(stream), 32'h8D);
        chk("basic_result", 32'(res), 32'h8D);
        chk("basic_carry", 32'(cy), 0);
        chk("basic_latency", 32'(ncyc), W);

        // overflow
        add_word(8'hFF, 8'h01, 32'h0, 0, ncyc, stream, res, cy);
        chk("ovf1_result", 32'(res), 32'h00);
        chk("ovf1_carry", 32'(cy), 1);
        add_word(8'hFF, 8'hFF, 32'h0, 0, ncyc, stream, res, cy);
        chk("ovf2_result", 32'(res), 32'hFE);
        chk("ovf2_carry", 32'(cy), 1);

        // stalls on ADD cycles 2 and 5
        add_word(8'h0F, 8'h01, 32'h24, 0, ncyc, stream, res, cy);
        chk("stall_result", 32'(res), 32'h10);
        chk("stall_carry", 32'(cy), 0);
        chk("stall_latency", 32'(ncyc), W + 2);

        // reset after four accepted bits of 0xFF+0x00
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.i_valid = 1'b1;
            bus.i_bit1  = 1'b1;
            bus.i_bit2  = 1'b0;
            step();
        end
        chk("pre_rst_result", 32'(bus.result), 32'hF0);
        rst = 1'b1;
        step();
        exp_sum = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_result", 32'(bus.result), 0);
        chk("midrst_carry", 32'(bus.carry), 0);
        chk("midrst_done", 32'(bus.done), 0);
        chk("midrst_sum_valid", 32'(bus.sum_valid), 0);
        chk("midrst_sum", 32'(bus.sum), 0);
        rst = 1'b0;
        bus.i_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_no_done", 32'(bus.done), 0);
            chk("post_rst_idle", 32'(bus.busy), 0);
        end
        add_word(8'h01, 8'h01, 32'h0, 0, ncyc, stream, res, cy);
        chk("fresh_result", 32'(res), 32'h02);

        // start held during ADD/DONE is ignored; next add begins right after done
        add_word(8'h5A, 8'h33, 32'h0, 1, ncyc, stream, res, cy);
        chk("proto_result", 32'(res), 32'h8D);
        chk("proto_carry", 32'(cy), 0);
        add_word(8'h80, 8'h80, 32'h0, 0, ncyc, stream, res, cy);
        chk("b2b_result", 32'(res), 32'h00);
        chk("b2b_carry", 32'(cy), 1);

        // random operands, random gaps and junk on start/valid/bits
        for (int n = 0; n < 500; n++) begin
            add_word(W'($urandom), W'($urandom), $urandom & $urandom, 2, ncyc, stream, res, cy);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
